wb_b3_burst_ram: RTL and testbench

Parametrised Wishbone B3 slave memory for the debug-interface system benches and small SoC builds, sitting on the bus driven by the debug unit's Wishbone master. Generalises the fixed single-port bench RAM with configurable data width, depth, base address and wait states. Adds full registered-feedback burst support: linear and 4/8/16-beat wrapping. Optional range checking returns bus errors.

---
 rtl/wb_b3_burst_ram_if.sv | 31 +++
 rtl/wb_b3_burst_ram.sv | 179 +++++++++++++++++
 tb/tb_wb_b3_burst_ram.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_b3_burst_ram_if.sv
// Wishbone B3 bus bundle for wb_b3_burst_ram.
// master drives requests, slave returns ack/err/data.
interface wb_b3_burst_ram_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic [AW-1:0]   wb_adr_i;
  logic [DW-1:0]   wb_dat_i;
  logic [DW/8-1:0] wb_sel_i;
  logic            wb_we_i;
  logic [2:0]      wb_cti_i;
  logic [1:0]      wb_bte_i;
  logic            wb_cyc_i;
  logic            wb_stb_i;
  logic            wb_ack_o;
  logic            wb_err_o;
  logic            wb_rty_o;
  logic [DW-1:0]   wb_dat_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i,
    output wb_cti_i, wb_bte_i, wb_cyc_i, wb_stb_i,
    input  wb_ack_o, wb_err_o, wb_rty_o, wb_dat_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i,
    input  wb_cti_i, wb_bte_i, wb_cyc_i, wb_stb_i,
    output wb_ack_o, wb_err_o, wb_rty_o, wb_dat_o
  );
endinterface

// File: rtl/wb_b3_burst_ram.sv
// Wishbone B3 burst RAM slave with wait states and wrap bursts.
// Optional range checking via WB_RAM_RANGE_CHECK_EN.
module wb_b3_burst_ram #(
  parameter int              DW          = 32,
  parameter int              AW          = 32,
  parameter int              MEM_WORDS   = 4096,
  parameter logic [AW-1:0]   BASE_ADDR   = '0,
  parameter int              WAIT_STATES = 0
) (
  input logic               wb_clk_i,
  input logic               wb_rst_n_i,
  wb_b3_burst_ram_if.slave  wb
);

  localparam int SW  = DW / 8;
  localparam int BSH = $clog2(SW);
  localparam int MW  = $clog2(MEM_WORDS);

  localparam logic [AW:0] LIM = (AW+1)'(MEM_WORDS * SW);
  localparam logic [2:0]  WS  = 3'(WAIT_STATES);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_ACK   = 2'd2;
  localparam logic [1:0] S_BURST = 2'd3;

  localparam logic [2:0] CTI_CONST = 3'b001;
  localparam logic [2:0] CTI_INCR  = 3'b010;
  localparam logic [2:0] CTI_END   = 3'b111;

  logic [DW-1:0] mem [MEM_WORDS];

  logic [1:0]    state;
  logic [2:0]    cnt;
  logic          burst;
  logic          incr;
  logic          err_pend;
  logic [1:0]    bte;
  logic [MW-1:0] adr;
  logic          ack;
  logic          err;
  logic [DW-1:0] dat;

  logic [AW-1:0] off;
  logic [MW-1:0] req_adr;
  logic          req;
  logic          req_burst;
  logic          req_ok;
  logic          top_err;
  logic          beat;
  logic          cyc;
  logic          stb;
  logic          last;
  logic          unused_ok;

  logic [MW-1:0] step;
  logic [MW-1:0] sum;
  logic [MW-1:0] mask;
  logic [MW-1:0] nxt;

  assign cyc       = wb.wb_cyc_i;
  assign stb       = wb.wb_stb_i;
  assign req       = cyc & stb;
  assign last      = (wb.wb_cti_i == CTI_END);
  assign req_burst = (wb.wb_cti_i == CTI_CONST) |
                     (wb.wb_cti_i == CTI_INCR);
  assign off       = wb.wb_adr_i - BASE_ADDR;
  assign req_adr   = off[BSH +: MW];
  assign beat      = ack & cyc & stb;
  assign unused_ok = &{1'b0, off};

`ifdef WB_RAM_RANGE_CHECK_EN
  assign req_ok  = ({1'b0, off} < LIM);
  assign top_err = incr & (bte == 2'b00) & (adr == '1);
`else
  assign req_ok  = 1'b1;
  assign top_err = 1'b0;
`endif

  // next burst word: low bits wrap inside the block, upper bits hold
  always_comb begin
    step = incr ? MW'(1) : '0;
    sum  = adr + step;
    unique case (bte)
      2'b01:   mask = MW'(3);
      2'b10:   mask = MW'(7);
      2'b11:   mask = MW'(15);
      default: mask = '1;
    endcase
    nxt = (adr & ~mask) | (sum & mask);
  end

  // bus FSM, registered ack/err and read data
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state    <= S_IDLE;
      cnt      <= '0;
      burst    <= 1'b0;
      incr     <= 1'b0;
      err_pend <= 1'b0;
      bte      <= '0;
      adr      <= '0;
      ack      <= 1'b0;
      err      <= 1'b0;
      dat      <= '0;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (req) begin
            adr      <= req_adr;
            burst    <= req_burst;
            incr     <= (wb.wb_cti_i == CTI_INCR);
            bte      <= wb.wb_bte_i;
            err_pend <= ~req_ok;
            if (WS == 3'd0) begin
              state <= S_ACK;
              if (req_ok) begin
                ack <= 1'b1;
                dat <= mem[req_adr];
              end else begin
                err <= 1'b1;
              end
            end else begin
              state <= S_WAIT;
              cnt   <= WS;
            end
          end
        end
        S_WAIT: begin
          cnt <= cnt - 3'd1;
          if (!cyc) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else if (cnt == 3'd1) begin
            state <= S_ACK;
            if (err_pend) begin
              err <= 1'b1;
            end else begin
              ack <= 1'b1;
              dat <= mem[adr];
            end
          end
        end
        S_ACK, S_BURST: begin
          if (!cyc || !stb || err || !burst || last) begin
            state <= S_IDLE;
          end else if (top_err) begin
            state <= S_ACK;
            err   <= 1'b1;
          end else begin
            state <= S_BURST;
            ack   <= 1'b1;
            adr   <= nxt;
            dat   <= mem[nxt];
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // byte-lane writes on each acked beat; none during reset
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_n_i && beat && wb.wb_we_i) begin
      for (int i = 0; i < SW; i++) begin
        if (wb.wb_sel_i[i])
          mem[adr][i*8 +: 8] <= wb.wb_dat_i[i*8 +: 8];
      end
    end
  end

  assign wb.wb_ack_o = ack;
  assign wb.wb_err_o = err;
  assign wb.wb_rty_o = 1'b0;
  assign wb.wb_dat_o = dat;

endmodule

// File: tb/tb_wb_b3_burst_ram.sv
// Bench for wb_b3_burst_ram: two instances (0 and 3 wait states)
// driven by a burst master and checked against a word-array model.
module tb_wb_b3_burst_ram;

  localparam int          MW   = 256;
  localparam logic [31:0] BASE = 32'h0001_0000;

  localparam logic [2:0] CLASSIC = 3'b000;
  localparam logic [2:0] CONSTB  = 3'b001;
  localparam logic [2:0] INCR    = 3'b010;
  localparam logic [2:0] ENDB    = 3'b111;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        dsel  = 1'b0;
  logic [31:0] adr   = '0;
  logic [31:0] wdat  = '0;
  logic [3:0]  sel   = '0;
  logic        we    = 1'b0;
  logic [2:0]  cti   = '0;
  logic [1:0]  bte   = '0;
  logic        cyc   = 1'b0;
  logic        stb   = 1'b0;
  logic        ack;
  logic        err;
  logic [31:0] rdat;
  logic [31:0] rd;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] mdl [2][MW];

  wb_b3_burst_ram_if #(.DW(32), .AW(32)) bus0 ();
  wb_b3_burst_ram_if #(.DW(32), .AW(32)) bus3 ();

  assign bus0.wb_adr_i = adr;
  assign bus0.wb_dat_i = wdat;
  assign bus0.wb_sel_i = sel;
  assign bus0.wb_we_i  = we;
  assign bus0.wb_cti_i = cti;
  assign bus0.wb_bte_i = bte;
  assign bus0.wb_cyc_i = cyc & ~dsel;
  assign bus0.wb_stb_i = stb & ~dsel;

  assign bus3.wb_adr_i = adr;
  assign bus3.wb_dat_i = wdat;
  assign bus3.wb_sel_i = sel;
  assign bus3.wb_we_i  = we;
  assign bus3.wb_cti_i = cti;
  assign bus3.wb_bte_i = bte;
  assign bus3.wb_cyc_i = cyc & dsel;
  assign bus3.wb_stb_i = stb & dsel;

  assign ack  = dsel ? bus3.wb_ack_o : bus0.wb_ack_o;
  assign err  = dsel ? bus3.wb_err_o : bus0.wb_err_o;
  assign rdat = dsel ? bus3.wb_dat_o : bus0.wb_dat_o;

  wb_b3_burst_ram #(
    .DW(32), .AW(32), .MEM_WORDS(MW),
    .BASE_ADDR(BASE), .WAIT_STATES(0)
  ) u_dut0 (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .wb         (bus0)
  );

  wb_b3_burst_ram #(
    .DW(32), .AW(32), .MEM_WORDS(MW),
    .BASE_ADDR(BASE), .WAIT_STATES(3)
  ) u_dut3 (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .wb         (bus3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int word_of(input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    return int'((o >> 2) % MW);
  endfunction

  function automatic int beat_word(input int w0, input logic [1:0] bt,
                                   input logic cst, input int b);
    int n;
    if (cst) return w0;
    if (bt == 2'b00) return (w0 + b) % MW;
    n = 2 << bt;
    return w0 - (w0 % n) + ((w0 % n) + b) % n;
  endfunction

  task automatic mwrite(input int d, input int w,
                        input logic [31:0] v, input logic [3:0] s);
    for (int i = 0; i < 4; i++)
      if (s[i]) mdl[d][w][i*8 +: 8] = v[i*8 +: 8];
  endtask

  // one bus cycle; s0 == 0 means random byte lanes on every beat
  task automatic xfer(input int d, input logic w, input logic [31:0] a,
                      input logic [1:0] bt, input logic cst, input int n,
                      input int stop_at, input int rst_at,
                      input logic [31:0] d0, input logic [3:0] s0,
                      output logic [31:0] rd0);
    logic [31:0] bd [16];
    logic [3:0]  bs [16];
    int ws, w0, ew, b, cc;
    logic done;
    ws = (d == 1) ? 3 : 0;
    w0 = word_of(a);
    ew = -1;
`ifdef WB_RAM_RANGE_CHECK_EN
    if (32'(a - BASE) >= 32'(MW * 4)) ew = 0;
    else if (!cst && bt == 2'b00 && n > 1 && w0 + n > MW) ew = MW - w0;
`endif
    for (int i = 0; i < 16; i++) begin
      bd[i] = $urandom;
      bs[i] = (s0 == 4'h0) ? 4'($urandom_range(1, 15)) : s0;
    end
    bd[0] = d0;
    rd0 = '0;
    dsel = (d == 1);
    we = w; adr = a; bte = bt;
    cti = (n == 1) ? CLASSIC : (cst ? CONSTB : INCR);
    wdat = bd[0]; sel = bs[0];
    cyc = 1'b1; stb = 1'b1;
    b = 0; cc = 0; done = 1'b0;
    forever begin
      @(posedge clk); #1;
      cc++;
      if (done) begin
        done = 1'b0;
        if (!rst_n) begin
          chk("rst_abort_ack", ack, 0);
          rst_n = 1'b1;
          break;
        end
        if (w) mwrite(d, beat_word(w0, bt, cst, b), bd[b], bs[b]);
        b++;
        if (b == n) begin
          chk("end_ack", {ack, err}, 0);
          break;
        end
        if (b == stop_at) begin
          stb = 1'b0;
          @(posedge clk); #1;
          chk("stb_drop_ack", ack, 0);
          break;
        end
        wdat = bd[b]; sel = bs[b];
        cti = (b == n - 1) ? ENDB : (cst ? CONSTB : INCR);
        if (b == rst_at) rst_n = 1'b0;
      end
      if (ack || err) begin
        chk("resp_kind", {ack, err}, (b == ew) ? 2'b01 : 2'b10);
        if (b == 0) chk("latency", cc, 1 + ws);
      end
      if (err) begin
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        chk("err_pulse", {ack, err}, 0);
        break;
      end
      if (ack) begin
        if (!w) begin
          chk("rdata", rdat, mdl[d][beat_word(w0, bt, cst, b)]);
          if (b == 0) rd0 = rdat;
        end
        done = 1'b1;
      end else if (b > 0 || cc >= 1 + ws) begin
        chk("ack_timeout", ack, 1);
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    int d, n, st;
    logic w, cst;
    logic [1:0] bt;
    logic [31:0] a;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack0", bus0.wb_ack_o, 0);
    chk("rst_err0", bus0.wb_err_o, 0);
    chk("rst_dat0", bus0.wb_dat_o, 0);
    chk("rst_rty0", bus0.wb_rty_o, 0);
    chk("rst_ack3", bus3.wb_ack_o, 0);
    chk("rst_err3", bus3.wb_err_o, 0);
    chk("rst_dat3", bus3.wb_dat_o, 0);
    chk("rst_rty3", bus3.wb_rty_o, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int di = 0; di < 2; di++)
      for (int blk = 0; blk < MW / 16; blk++)
        xfer(di, 1, BASE + 32'(blk * 64), 2'b00, 0, 16, 0, -1,
             $urandom, 4'hf, rd);

    xfer(0, 1, BASE + 32'h10, 0, 0, 1, 0, -1, 32'hDEADBEEF, 4'hf, rd);
    xfer(0, 0, BASE + 32'h10, 0, 0, 1, 0, -1, 0, 4'hf, rd);
    chk("deadbeef0", rd, 32'hDEADBEEF);
    xfer(1, 1, BASE + 32'h10, 0, 0, 1, 0, -1, 32'hDEADBEEF, 4'hf, rd);
    xfer(1, 0, BASE + 32'h10, 0, 0, 1, 0, -1, 0, 4'hf, rd);
    chk("deadbeef3", rd, 32'hDEADBEEF);

    xfer(0, 1, BASE + 32'h14, 0, 0, 1, 0, -1, 32'h11223344, 4'hf, rd);
    xfer(0, 1, BASE + 32'h14, 0, 0, 1, 0, -1, 32'hAABBCCDD, 4'b0101, rd);
    xfer(0, 0, BASE + 32'h14, 0, 0, 1, 0, -1, 0, 4'hf, rd);
    chk("byte_lanes", rd, 32'h11BB33DD);

    for (int i = 4; i < 8; i++)
      xfer(0, 1, BASE + 32'(i * 4), 0, 0, 1, 0, -1, 32'(i), 4'hf, rd);
    xfer(0, 0, BASE + 32'(6 * 4), 2'b01, 0, 4, 0, -1, 0, 4'hf, rd);
    chk("wrap4_first", rd, 32'd6);

    xfer(0, 1, BASE + 32'(32 * 4), 2'b00, 0, 8, 3, -1, $urandom, 4'hf, rd);
    xfer(0, 0, BASE + 32'(32 * 4), 2'b00, 0, 8, 0, -1, 0, 4'hf, rd);
    xfer(0, 1, BASE + 32'(48 * 4), 2'b00, 0, 8, 0, 2, $urandom, 4'hf, rd);
    chk("rst_mid_dat0", bus0.wb_dat_o, 0);
    xfer(0, 0, BASE + 32'(48 * 4), 2'b00, 0, 8, 0, -1, 0, 4'hf, rd);

    xfer(0, 0, BASE + 32'(MW * 4), 0, 0, 1, 0, -1, 0, 4'hf, rd);
    xfer(1, 0, BASE + 32'(MW * 4), 0, 0, 1, 0, -1, 0, 4'hf, rd);
    xfer(0, 0, BASE + 32'((MW - 2) * 4), 2'b00, 0, 4, 0, -1, 0, 4'hf, rd);
    xfer(1, 1, BASE + 32'((MW - 2) * 4), 2'b00, 0, 4, 0, -1,
         $urandom, 4'hf, rd);

    for (int r = 0; r < 80; r++) begin
      d   = $urandom_range(0, 1);
      w   = 1'($urandom_range(0, 1));
      bt  = 2'($urandom_range(0, 3));
      cst = ($urandom_range(0, 3) == 0);
      n   = ($urandom_range(0, 3) == 0) ? 1 : $urandom_range(2, 16);
      st  = (n > 1 && $urandom_range(0, 4) == 0) ?
            $urandom_range(1, n - 1) : 0;
      a   = BASE + 32'($urandom_range(0, MW - 1) * 4)
                 + 32'($urandom_range(0, 3));
      xfer(d, w, a, bt, cst, n, st, -1, $urandom, 4'h0, rd);
    end

    for (int di = 0; di < 2; di++)
      for (int blk = 0; blk < MW / 16; blk++)
        xfer(di, 0, BASE + 32'(blk * 64), 2'b00, 0, 16, 0, -1,
             0, 4'hf, rd);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
